// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial front end for one-bit sequence detectors.
// Accepts WIDTH-bit words over valid/ready and emits one bit per clock on dout.
// A word that arrives on the last bit of the previous word streams with no gap.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             at_last;
  logic             take;

  // The bit on dout is registered, so the load edge already presents the
  // first bit and shreg only holds the bits still to be sent.
  assign at_last   = (state == SHIFT) && (cnt == LAST);
  assign din_ready = !abort && ((state == IDLE) || at_last);
  assign take      = din_valid && din_ready;
  assign busy      = (state == SHIFT);

  // Serializer state, counter, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      dout        <= IDLE_BIT;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      dout        <= IDLE_BIT;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else if (take) begin
      state       <= SHIFT;
      cnt         <= '0;
      dout_valid  <= 1'b1;
      frame_start <= 1'b1;
      if (MSB_FIRST) begin
        dout  <= din[WIDTH-1];
        shreg <= {din[WIDTH-2:0], 1'b0};
      end else begin
        dout  <= din[0];
        shreg <= {1'b0, din[WIDTH-1:1]};
      end
    end else if ((state == SHIFT) && !at_last) begin
      cnt         <= cnt + CW'(1);
      dout_valid  <= 1'b1;
      frame_start <= 1'b0;
      if (MSB_FIRST) begin
        dout  <= shreg[WIDTH-1];
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        dout  <= shreg[0];
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
    end else begin
      state       <= IDLE;
      cnt         <= '0;
      dout        <= IDLE_BIT;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Parallel-to-serial front end that feeds the one-bit `data` input of the FSM sequence-detector stages (for example the non-overlapping "1011" detector).
Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clk on `dout`, MSB-first by default.
Back-to-back words stream with no idle gap between them.
Idle cycles drive a fixed IDLE_BIT so the downstream detector sees a defined level.

Parameters:
WIDTH, 8, word width in bits (legal range 2..32)
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first
IDLE_BIT, 0, value driven on dout while no word is being sent

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-low
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a valid word
din_ready  output  1  block can accept din this cycle (combinational)
abort  input  1  synchronous; drops the word in flight
dout  output  1  serial bit to the detector's data input (registered)
dout_valid  output  1  dout carries a payload bit (registered)
frame_start  output  1  high with the first bit of each word (registered)
busy  output  1  high while in SHIFT (registered state decode)

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, bit counter = 0, shift register = 0
  - dout = IDLE_BIT, dout_valid = 0, frame_start = 0, busy = 0
  - Reset mid-word discards the word. No partial bits appear after reset release.
- States: IDLE, SHIFT. The bit counter cnt is $clog2(WIDTH) bits wide.
- din_ready = !abort && (state == IDLE || (state == SHIFT && cnt == WIDTH-1)).
- Handshake: a transfer occurs at the rising edge where din_valid && din_ready. din is sampled on that edge only.
- IDLE:
  - On handshake: load the shift register, go to SHIFT, cnt = 0.
  - Next cycle: dout = first bit, dout_valid = 1, frame_start = 1.
  - Otherwise: dout = IDLE_BIT, dout_valid = 0.
- SHIFT, one bit per cycle:
  - Output order is din[WIDTH-1] down to din[0] when MSB_FIRST = 1, and din[0] up to din[WIDTH-1] when MSB_FIRST = 0.
  - cnt increments each cycle while cnt < WIDTH-1. frame_start = 0 after the first bit.
- Last bit (cnt == WIDTH-1):
  - With a handshake: reload, cnt = 0. The next cycle carries the new word's first bit with frame_start = 1. No gap.
  - Without a handshake: go to IDLE. The next cycle has dout = IDLE_BIT and dout_valid = 0.
- Latency: handshake edge to first dout bit = 1 cycle. A word occupies exactly WIDTH dout_valid cycles.
- Abort:
  - Sampled at each rising edge, priority over everything except reset.
  - Forces IDLE, cnt = 0. Next cycle: dout = IDLE_BIT, dout_valid = 0, frame_start = 0.
  - din_ready is low while abort is high, so no word is accepted on an abort edge.
  - Abort in IDLE has no effect beyond blocking acceptance.
- din_valid is ignored whenever din_ready is low. Upstream must hold din/din_valid until the transfer.
- busy = (state == SHIFT).

Test Plan:
- Reset then single word, WIDTH=8, MSB_FIRST=1, din=8'hB0 with one-cycle valid:
  - Expect dout = 1,0,1,1,0,0,0,0 over 8 consecutive dout_valid cycles, frame_start only on the first.
  - Then dout = IDLE_BIT and dout_valid = 0.
  - With the "1011" detector attached, flag pulses the cycle after the 4th bit.
- Back-to-back words, din_valid held high with 8'hA5 then 8'h3C:
  - Expect 16 contiguous valid bits 10100101 00111100.
  - din_ready high only in IDLE and on the cnt = 7 cycles.
  - frame_start high on bits 0 and 8.
- MSB_FIRST=0, din=8'h0D:
  - Expect dout = 1,0,1,1,0,0,0,0 (LSB first), same total length of 8.
- Abort asserted during bit 3 of 8'hFF:
  - Exactly 3 ones emitted, then dout = IDLE_BIT and dout_valid = 0 from the next cycle.
  - din_valid asserted during abort is not accepted; it is accepted on the first cycle after abort drops.
- Asynchronous reset pulse (no clock edge) during bit 5:
  - Outputs go to reset values immediately.
  - After release with din_valid = 0, dout stays IDLE_BIT and dout_valid = 0 indefinitely.
- Stall: din_valid low for 5 cycles between words:
  - dout_valid = 0 and dout = IDLE_BIT for exactly those idle cycles.
  - 1-cycle latency from the next handshake to the first bit.
